i2c_status_clr_ctrl: RTL and testbench



---
 rtl/i2c_status_clr_ctrl.sv | 102 ++++++++++
 tb/tb_i2c_status_clr_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/i2c_status_clr_ctrl.sv
// i2c_status_clr_ctrl: read-to-clear sequencer for the I2C sticky status register.
// Rev 1.0 - initial release.
`default_nettype none

module i2c_status_clr_ctrl #(
  parameter int                  STATUS_W    = 13,
  parameter logic [STATUS_W-1:0] STICKY_MASK = 13'h126D,
  parameter int                  CLR_LAT     = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [STATUS_W-1:0] status_in,
  input  logic [STATUS_W-1:0] irq_mask,
  input  logic                rd_req,
  input  logic                sw_clr_req,
  output logic                clear,
  output logic [STATUS_W-1:0] rd_data,
  output logic                rd_valid,
  output logic                busy,
  output logic                irq,
  output logic [3:0]          drop_cnt
);

  localparam int CNT_W = (CLR_LAT > 1) ? $clog2(CLR_LAT + 1) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(CLR_LAT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] hold_cnt;
  logic             rd_pend;

  logic       rd_any;
  logic       drop_rd;
  logic       drop_sw;
  logic [4:0] drop_sum;

  always_comb begin
    rd_any   = rd_req | rd_pend;
    drop_rd  = (state != IDLE) & rd_req & rd_pend;
    drop_sw  = (state != IDLE) & sw_clr_req;
    drop_sum = {1'b0, drop_cnt} + 5'(drop_rd) + 5'(drop_sw);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      hold_cnt <= '0;
      rd_pend  <= 1'b0;
      clear    <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      busy     <= 1'b0;
      irq      <= 1'b0;
      drop_cnt <= 4'd0;
    end else begin
      clear    <= 1'b0;
      rd_valid <= 1'b0;
      irq      <= (state == IDLE) ? |(status_in & irq_mask & STICKY_MASK) : 1'b0;
      drop_cnt <= (drop_sum > 5'd15) ? 4'd15 : drop_sum[3:0];

      case (state)
        IDLE: begin
          // Reads and a firmware clear arriving together share one sequence.
          if (rd_any || sw_clr_req) begin
            state    <= CLEAR;
            clear    <= 1'b1;
            rd_valid <= rd_any;
            rd_data  <= status_in;
            busy     <= 1'b1;
            rd_pend  <= 1'b0;
          end
        end
        CLEAR: begin
          if (rd_req) rd_pend <= 1'b1;
          state    <= HOLD;
          hold_cnt <= '0;
        end
        HOLD: begin
          if (rd_req) rd_pend <= 1'b1;
          if (hold_cnt == HOLD_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_i2c_status_clr_ctrl.sv
// tb_i2c_status_clr_ctrl: directed self-checking bench for i2c_status_clr_ctrl.
// Rev 1.0 - initial release.
`default_nettype none

module tb_i2c_status_clr_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] status_in;
  logic [12:0] irq_mask;
  logic        rd_req;
  logic        sw_clr_req;
  logic        clear;
  logic [12:0] rd_data;
  logic        rd_valid;
  logic        busy;
  logic        irq;
  logic [3:0]  drop_cnt;

  int checks   = 0;
  int failures = 0;

  i2c_status_clr_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .status_in  (status_in),
    .irq_mask   (irq_mask),
    .rd_req     (rd_req),
    .sw_clr_req (sw_clr_req),
    .clear      (clear),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .busy       (busy),
    .irq        (irq),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled and inputs changed 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    check("wait_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int clr_seen;
    int vld_seen;

    rst = 1'b1; status_in = '0; irq_mask = '0; rd_req = 1'b0; sw_clr_req = 1'b0;
    tick(); tick();
    check("rst_clear",    {31'd0, clear},    32'd0);
    check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_busy",     {31'd0, busy},     32'd0);
    check("rst_irq",      {31'd0, irq},      32'd0);
    check("rst_drop",     {28'd0, drop_cnt}, 32'd0);
    check("rst_rd_data",  {19'd0, rd_data},  32'd0);
    rst = 1'b0;

    // Idle interrupt path, and a non-sticky bit must not raise irq.
    status_in = 13'h0001; irq_mask = 13'h0001;
    tick();
    check("irq_sticky", {31'd0, irq}, 32'd1);
    status_in = 13'h0002; irq_mask = 13'h1FFF;
    tick();
    check("irq_nonsticky", {31'd0, irq}, 32'd0);

    // Single read with irq suppression across the sequence.
    status_in = 13'h126D; irq_mask = 13'h1FFF;
    rd_req = 1'b1;
    tick();                                        // t+1
    rd_req = 1'b0;
    check("rd_clear",   {31'd0, clear},    32'd1);
    check("rd_valid",   {31'd0, rd_valid}, 32'd1);
    check("rd_data",    {19'd0, rd_data},  32'h126D);
    check("rd_busy1",   {31'd0, busy},     32'd1);
    check("rd_irq1",    {31'd0, irq},      32'd1);
    tick();                                        // t+2
    check("rd_clear_off", {31'd0, clear},    32'd0);
    check("rd_valid_off", {31'd0, rd_valid}, 32'd0);
    check("rd_irq2",      {31'd0, irq},      32'd0);
    tick(); tick();                                // t+4
    check("rd_busy4", {31'd0, busy}, 32'd1);
    tick();                                        // t+5
    check("rd_busy5", {31'd0, busy}, 32'd0);
    check("rd_irq5",  {31'd0, irq},  32'd0);
    tick();                                        // t+6
    check("rd_irq6",  {31'd0, irq},  32'd1);
    irq_mask = '0;

    // Simultaneous read and firmware clear: one sequence, non-sticky bits passed through.
    status_in = 13'h1A5A;
    rd_req = 1'b1; sw_clr_req = 1'b1;
    tick();
    rd_req = 1'b0; sw_clr_req = 1'b0;
    check("sim_clear",   {31'd0, clear},    32'd1);
    check("sim_valid",   {31'd0, rd_valid}, 32'd1);
    check("sim_rd_data", {19'd0, rd_data},  32'h1A5A);
    check("sim_drop",    {28'd0, drop_cnt}, 32'd0);
    clr_seen = 0; vld_seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      clr_seen += int'(clear);
      vld_seen += int'(rd_valid);
    end
    check("sim_extra_clear", clr_seen, 32'd0);
    check("sim_extra_valid", vld_seen, 32'd0);

    // Firmware clear alone.
    sw_clr_req = 1'b1;
    tick();
    sw_clr_req = 1'b0;
    check("sw_clear", {31'd0, clear},    32'd1);
    check("sw_valid", {31'd0, rd_valid}, 32'd0);
    wait_idle();

    // Queued read at t+2 and a dropped read at t+3.
    status_in = 13'h0F0F;
    rd_req = 1'b1;
    tick();                                        // t+1
    rd_req = 1'b0;
    tick();                                        // t+2
    rd_req = 1'b1;
    tick();                                        // t+3
    check("q_drop0", {28'd0, drop_cnt}, 32'd0);
    tick();                                        // t+4
    rd_req = 1'b0;
    check("q_drop1", {28'd0, drop_cnt}, 32'd1);
    tick();                                        // t+5
    check("q_idle5", {31'd0, busy},  32'd0);
    check("q_clr5",  {31'd0, clear}, 32'd0);
    tick();                                        // t+6
    check("q_clear6", {31'd0, clear},    32'd1);
    check("q_valid6", {31'd0, rd_valid}, 32'd1);
    wait_idle();

    // Saturation: firmware clear held high drops well over 15 strobes.
    sw_clr_req = 1'b1;
    for (int i = 0; i < 30; i++) tick();
    sw_clr_req = 1'b0;
    check("sat_drop", {28'd0, drop_cnt}, 32'd15);
    wait_idle();
    check("sat_hold", {28'd0, drop_cnt}, 32'd15);

    // Reset in HOLD with a pending read: sequence aborts and the pending read is lost.
    rd_req = 1'b1;
    tick();                                        // t+1
    rd_req = 1'b0;
    tick();                                        // t+2
    rd_req = 1'b1;
    tick();                                        // t+3
    rd_req = 1'b0;
    rst = 1'b1;
    tick();                                        // t+4
    rst = 1'b0;
    check("mrst_busy",  {31'd0, busy},     32'd0);
    check("mrst_clear", {31'd0, clear},    32'd0);
    check("mrst_drop",  {28'd0, drop_cnt}, 32'd0);
    clr_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      clr_seen += int'(clear);
    end
    check("mrst_no_clear", clr_seen, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
